// File: rtl/route_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : route_pkg                                                     |
// | Purpose    : Shared defaults and select encodings for the route_demux      |
// |              one-to-two routing demultiplexer.                             |
// | Contents   : WIDTH/DEPTH defaults, occupancy and pointer widths, routed   |
// |              counter width, output select encodings.                       |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package route_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 2;

  // Occupancy must be able to represent DEPTH itself so full != empty.
  localparam int CNT_W_DEF = $clog2(DEPTH_DEF + 1);
  localparam int PTR_W_DEF = $clog2(DEPTH_DEF);

  localparam int ROUTED_W = 16;

  localparam logic ROUTE_OUT0 = 1'b0;
  localparam logic ROUTE_OUT1 = 1'b1;

endpackage : route_pkg
`default_nettype wire

// File: rtl/route_demux_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface  : route_demux_if                                                |
// | Purpose    : Bundles the input handshake, the two output handshakes and    |
// |              the status outputs of route_demux.                            |
// | Ports      : in_data/in_sel/in_valid/in_ready   - routed input stream      |
// |              outN_data/outN_valid/outN_ready    - per-output streams       |
// |              countN                             - queue occupancy          |
// |              routedN                            - wrapping accept counters |
// | Modports   : slave  - the demux itself                                     |
// |              master - the environment driving input and consuming outputs  |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface route_demux_if
  import route_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
);

  logic [WIDTH-1:0]             in_data;
  logic                         in_sel;
  logic                         in_valid;
  logic                         in_ready;

  logic [WIDTH-1:0]             out0_data;
  logic                         out0_valid;
  logic                         out0_ready;

  logic [WIDTH-1:0]             out1_data;
  logic                         out1_valid;
  logic                         out1_ready;

  logic [$clog2(DEPTH+1)-1:0]   count0;
  logic [$clog2(DEPTH+1)-1:0]   count1;
  logic [ROUTED_W-1:0]          routed0;
  logic [ROUTED_W-1:0]          routed1;

  modport slave (
    input  in_data, in_sel, in_valid, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid,
           count0, count1, routed0, routed1
  );

  modport master (
    output in_data, in_sel, in_valid, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid,
           count0, count1, routed0, routed1
  );

endinterface : route_demux_if
`default_nettype wire

// File: rtl/route_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : route_fifo                                                    |
// | Purpose    : Single-clock FIFO used as one output queue of route_demux.    |
// |              No full- or empty-bypass; head reads as zero when empty.      |
// | Ports      : clk, rst_n            - clock, async active-low reset         |
// |              push, push_data       - write request and word                |
// |              pop                   - remove head                           |
// |              head_data             - head entry (zero when empty)          |
// |              full, empty, count    - occupancy status                      |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module route_fifo
  import route_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] occ;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (occ == CNT_W'(DEPTH));
  assign empty   = (occ == '0);
  // A push into a full queue is refused even if the head leaves this cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign count   = occ;

  // Storage is deliberately not reset; empty masks it on the output.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule : route_fifo
`default_nettype wire

// File: rtl/route_demux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : route_demux                                                   |
// | Purpose    : One-to-two routing demultiplexer. Steers each accepted input  |
// |              word by in_sel into one of two independent FIFO queues and    |
// |              counts words routed to each output (16-bit, wrapping).        |
// | Ports      : clk    - clock, rising edge                                   |
// |              rst_n  - asynchronous active-low reset                        |
// |              bus    - route_demux_if.slave: input stream, two output       |
// |                       streams, occupancy counts and routed counters        |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module route_demux
  import route_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  route_demux_if.slave  bus
);

  logic                full0;
  logic                full1;
  logic                empty0;
  logic                empty1;
  logic                accept;
  logic                push0;
  logic                push1;
  logic                pop0;
  logic                pop1;
  logic [ROUTED_W-1:0] routed0;
  logic [ROUTED_W-1:0] routed1;

  // Ready looks only at the selected queue's registered occupancy, never at
  // in_valid or the consumers' readies.
  assign bus.in_ready = (bus.in_sel == ROUTE_OUT1) ? !full1 : !full0;

  assign accept = bus.in_valid && bus.in_ready;
  assign push0  = accept && (bus.in_sel == ROUTE_OUT0);
  assign push1  = accept && (bus.in_sel == ROUTE_OUT1);
  assign pop0   = !empty0 && bus.out0_ready;
  assign pop1   = !empty1 && bus.out1_ready;

  route_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0),
    .push_data (bus.in_data),
    .pop       (pop0),
    .head_data (bus.out0_data),
    .full      (full0),
    .empty     (empty0),
    .count     (bus.count0)
  );

  route_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .push_data (bus.in_data),
    .pop       (pop1),
    .head_data (bus.out1_data),
    .full      (full1),
    .empty     (empty1),
    .count     (bus.count1)
  );

  assign bus.out0_valid = !empty0;
  assign bus.out1_valid = !empty1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      routed0 <= '0;
      routed1 <= '0;
    end else begin
      if (push0) routed0 <= routed0 + ROUTED_W'(1);
      if (push1) routed1 <= routed1 + ROUTED_W'(1);
    end
  end

  assign bus.routed0 = routed0;
  assign bus.routed1 = routed1;

endmodule : route_demux
`default_nettype wire

// File: doc/route_demux.md
# route_demux

One-to-two routing demultiplexer for the datapath: the distributing counterpart of the 2:1 word select `Mux`. It accepts one 32-bit word per cycle on a valid/ready input, steers it by a select bit into one of two per-output FIFO queues, and presents each queue on its own valid/ready output. Each output stalls independently, so one blocked consumer never corrupts or reorders traffic to the other. Per-output wrap-around counters record how many words were routed.

## Interface
- `WIDTH`, 32: data word width in bits.
- `DEPTH`, 2: entries per output queue; power of two, ≥2.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `in_data` input WIDTH: word to route.
- `in_sel` input 1: 0 routes to output 0, 1 routes to output 1.
- `in_valid` input 1: `in_data` and `in_sel` are valid.
- `in_ready` output 1: the selected queue can accept a word.
- `out0_data` output WIDTH: head of queue 0.
- `out0_valid` output 1: queue 0 is non-empty.
- `out0_ready` input 1: consumer 0 takes the head.
- `out1_data`, `out1_valid`, `out1_ready`: same as above, for queue 1.
- `count0` output $clog2(DEPTH+1): current occupancy of queue 0.
- `count1` output $clog2(DEPTH+1): current occupancy of queue 1.
- `routed0` output 16: words accepted into queue 0. Wraps.
- `routed1` output 16: words accepted into queue 1. Wraps.

## Operation
- **Accept (push).** Occurs when `in_valid && in_ready`. The word is pushed into queue `in_sel`.
- **Input ready.**
  - `in_ready = !full[in_sel]`. This is combinational from `in_sel` and registered occupancy only.
  - It never depends on `in_valid` or on either `outN_ready`.
- **Pop.** Occurs when `outN_valid && outN_ready`. The head of queue N is removed.
- **Output valid.** `outN_valid = (countN != 0)`.
- **Output data.**
  - `outN_data` is the head entry.
  - It is driven to all zeros while the queue is empty.
- **Ordering.**
  - Each queue is strict FIFO.
  - There is no ordering guarantee between queues.
- **Push and pop on the same queue in one cycle.**
  - Occupancy is unchanged.
  - Both pointers advance.
  - Allowed whenever the queue is neither full nor empty.
- **Full queue.**
  - Push is refused, even if a pop occurs on the same cycle. There is no full-bypass.
  - The input holds until the next cycle.
- **Empty queue.**
  - There is no empty-bypass.
  - A pushed word becomes visible the next cycle.
- **Pointers.**
  - Read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
  - Occupancy is tracked by a separate counter, so a full queue is distinguishable from an empty one.
- **Routed counters.**
  - `routedN` increments by 1 on each accept into queue N.
  - It wraps from 16'hFFFF to 16'h0000.
  - Pops do not affect it.
- **Reset.**
  - While `rst_n` = 0, regardless of clock:
    - all pointers, occupancies and routed counters are 0;
    - `out0_valid` and `out1_valid` are 0;
    - `out0_data` and `out1_data` are 0;
    - `in_ready` is 1.
  - Assertion mid-transfer discards all queued words. No partial state survives.
- **Storage.** Queue storage RAM is not reset; it is masked by the zero-when-empty output rule.

## Timing
- Input-to-output latency is 1 cycle: a word accepted at edge k is on `outN_data` with `outN_valid` = 1 after edge k.
- Throughput:
  - 1 word per cycle sustained into either queue while its consumer holds ready high.
  - At DEPTH=2, one word is in flight and one is buffered.
- `in_ready` updates the cycle after a pop frees a full queue.
- Outputs `outN_valid`, `countN` and `routedN` are registered. `outN_data` is a mux of registered storage.
- Combinational paths:
  - `in_sel` → `in_ready`.
  - No path from any ready input to any output.

## Structure
- Package `route_pkg` holds:
  - the `WIDTH` default;
  - the `DEPTH` default;
  - the occupancy-width and pointer-width constants;
  - the `ROUTE_OUT0 = 1'b0` and `ROUTE_OUT1 = 1'b1` select encodings.
- One sub-module, `route_fifo`:
  - parameterised by WIDTH and DEPTH;
  - ports: push, pop, data, full, empty, count;
  - instantiated twice.
- The top level holds the steering logic, `in_ready` generation and the routed counters.

## Test plan
- **Reset.**
  - Stimulus: assert `rst_n` = 0 mid-stream with both queues holding data.
  - Required: immediately `out0_valid` = `out1_valid` = 0, both data outputs 0, `count0` = `count1` = 0, `routed0` = `routed1` = 0, `in_ready` = 1.
- **Basic routing.**
  - Stimulus: push 32'hA5A5_0001 with sel=0, then 32'h5A5A_0002 with sel=1; both readies high.
  - Required: each word appears one cycle after acceptance on the correct output only; `routed0` = `routed1` = 1.
- **Backpressure isolation.**
  - Stimulus: `out0_ready` = 0; push 3 words to sel=0 and 3 words to sel=1 alternately.
  - Required: `count0` saturates at 2 and `in_ready` = 0 whenever sel=0; queue 1 drains all 3 words in order.
- **Full with same-cycle pop.**
  - Stimulus: queue 0 full; pulse `out0_ready` while `in_valid` = 1 with sel=0.
  - Required: the pop happens and the push is refused that cycle; the push is accepted next cycle; FIFO order is preserved.
- **Counter wrap.**
  - Stimulus: 65 537 accepts to queue 1.
  - Required: `routed1` = 16'h0001; `routed0` unchanged.
- **Streaming.**
  - Stimulus: 100 random words with random sel and random readies.
  - Required: a scoreboard per output matches order and values exactly, with no drops and no duplicates.
